pipe_stage_skid: RTL

Parametrised pipeline stage register that generalises the fixed IF/ID register. It carries an arbitrary-width payload, such as {pc, instr} or later-stage bundles, with a valid/ready handshake, stall and flush. A two-entry skid buffer gives full throughput with a registered in_ready. It drops in between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Purpose : generic pipeline stage register with a two-entry skid buffer (main + skid).
// Latency : 1 cycle from in_fire to out_valid; sustains 1 payload/cycle.
// Backpressure: in_ready comes from registered state only (drops when both entries
//               are full); stall or ~out_ready holds the output stable.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   flush                   drop all buffered entries; payload registers keep contents
//   stall                   downstream hold, blocks output transfer
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload (main register)
//   occupancy               buffered entries, 0..2
//   stall_cnt, flush_cnt    performance counters, present only with
//                           PIPE_STAGE_SKID_PERF_EN defined (tied to 0 otherwise)
module pipe_stage_skid #(
  parameter int unsigned          PAYLOAD_W = 64,
  parameter logic [PAYLOAD_W-1:0] RESET_VAL = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PAYLOAD_W-1:0]   r_main;
  logic [PAYLOAD_W-1:0]   r_skid;

  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_main_from_in;
  logic                   w_main_from_skid;
  logic                   w_skid_from_in;

  // Valid bits of the two entries follow directly from the state encoding.
  logic                   w_main_vld;
  logic                   w_skid_vld;

  assign w_main_vld = (r_state != S_EMPTY);
  assign w_skid_vld = (r_state == S_FULL);

  // in_ready deliberately ignores out_ready/stall so it can be a registered path.
  assign in_ready   = ~reset & ~w_skid_vld;
  assign out_valid  = w_main_vld;
  assign out_data   = r_main;
  assign occupancy  = {w_skid_vld, w_main_vld & ~w_skid_vld};

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_main  <= RESET_VAL;
      r_skid  <= RESET_VAL;
    end else begin
      r_state <= w_state_nxt;
      if (w_main_from_in) begin
        r_main <= in_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_from_in) begin
        r_skid <= in_data;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    if (flush) begin
      // Any payload accepted this cycle is consumed and discarded; data regs untouched.
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt    = S_ONE;
            w_main_from_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_from_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt    = S_FULL;
            w_skid_from_in = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt    = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_nxt      = S_ONE;
            w_main_from_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;
  logic             w_flush_inc;

  assign w_stall_inc = out_valid & (~out_ready | stall) & ~flush;
  assign w_flush_inc = flush & w_main_vld;

  // Saturating counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
